// File: rtl/wb_sdr_traffic_gen_if.sv
// rtl/wb_sdr_traffic_gen_if.sv - Wishbone burst bus between the traffic generator and the SDRAM controller slave
interface wb_sdr_traffic_gen_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_addr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_dat_i
  );
endinterface

// File: rtl/wb_sdr_traffic_gen.sv
// rtl/wb_sdr_traffic_gen.sv - Wishbone burst master writing LFSR-keyed groups and checking the read-back
module wb_sdr_traffic_gen #(
  parameter int          DW      = 32,
  parameter int          AW      = 26,
  parameter int          BLW     = 4,
  parameter int          QDEPTH  = 8,
  parameter int          TIMEOUT = 1024,
  parameter logic [31:0] SEED    = 32'hACE1
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic [1:0]           mode,
  input  logic [AW-1:0]        cfg_base_addr,
  input  logic [AW-1:0]        cfg_addr_mask,
  input  logic [BLW-1:0]       cfg_bl_mask,
  input  logic [3:0]           cfg_group,
  input  logic [15:0]          cfg_num_iter,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout_err,
  output logic [31:0]          err_cnt,
  output logic [AW-1:0]        first_err_addr,
  wb_sdr_traffic_gen_if.master wb
);
  localparam int          NB   = DW / 8;
  localparam int          LSB  = $clog2(NB);
  localparam int          QAW  = $clog2(QDEPTH);
  localparam int          TW   = $clog2(TIMEOUT + 1);
  localparam logic [31:0] TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {S_IDLE, S_GEN, S_WR, S_POP, S_RD, S_DONE} state_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [BLW:0]  bl;
    logic [31:0]   key;
  } desc_t;

  state_t         state, state_nxt;
  desc_t          q_mem [QDEPTH];
  logic [QAW-1:0] q_wr_ptr, q_rd_ptr;
  logic [QAW:0]   q_count;

  logic [1:0]     mode_r;
  logic [AW-1:0]  base_r, mask_r, offset;
  logic [BLW-1:0] blm_r;
  logic [QAW:0]   grp_r, grp_clamped;
  logic [15:0]    iter_r;
  logic [31:0]    lfsr, lfsr_next;

  logic [AW-1:0]  cur_addr;
  logic [BLW:0]   beats_left;
  logic [31:0]    cur_key;
  logic [TW-1:0]  wait_cnt;

  logic [AW-1:0]  gen_addr;
  logic [BLW:0]   gen_bl;
  logic [DW-1:0]  pattern;
  logic           in_burst, beat_ack, last_beat, timeout_hit, accept_start;

  assign in_burst     = (state == S_WR) || (state == S_RD);
  assign beat_ack     = in_burst && wb.wb_ack_i;
  assign last_beat    = (beats_left == (BLW+1)'(1));
  assign timeout_hit  = in_burst && !wb.wb_ack_i && (wait_cnt == TW'(TIMEOUT));
  assign accept_start = start && ((state == S_IDLE) || (state == S_DONE));
  assign pattern      = DW'(cur_key) ^ DW'(cur_addr);
  assign lfsr_next    = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  always_comb begin
    grp_clamped = (QAW+1)'(cfg_group);
    if (cfg_group == 4'd0)
      grp_clamped = (QAW+1)'(1);
    else if (32'(cfg_group) > QDEPTH)
      grp_clamped = (QAW+1)'(QDEPTH);
  end

  // Random mode aligns the final sum so every beat stays on a full-width lane boundary.
  always_comb begin
    gen_addr = base_r;
    gen_bl   = (BLW+1)'(blm_r) + (BLW+1)'(1);
    case (mode_r)
      2'b00: gen_addr = base_r;
      2'b01: gen_addr = base_r + (offset & mask_r);
      default: begin
        gen_addr = (base_r + (AW'(lfsr) & mask_r)) & ~AW'(NB - 1);
        gen_bl   = (BLW+1)'(lfsr[BLW-1:0] & blm_r) + (BLW+1)'(1);
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    busy            = (state != S_IDLE) && (state != S_DONE);
    wb.wb_cyc_o     = in_burst;
    wb.wb_stb_o     = in_burst;
    wb.wb_we_o      = (state == S_WR);
    wb.wb_sel_o     = in_burst ? '1 : '0;
    wb.wb_cti_o     = !in_burst ? 3'b000 : (last_beat ? 3'b111 : 3'b010);
    wb.wb_addr_o    = cur_addr;
    wb.wb_dat_o     = (state == S_WR) ? pattern : '0;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (accept_start) state_nxt = (cfg_num_iter == 16'd0) ? S_DONE : S_GEN;
      end
      S_GEN: state_nxt = S_WR;
      S_WR: begin
        if (beat_ack && last_beat)
          state_nxt = (q_count == grp_r || q_count == (QAW+1)'(QDEPTH)) ? S_POP : S_GEN;
        else if (timeout_hit)
          state_nxt = S_DONE;
      end
      S_POP: state_nxt = S_RD;
      S_RD: begin
        if (beat_ack && last_beat) begin
          if (q_count != '0)               state_nxt = S_POP;
          else if (iter_r == 16'd1)        state_nxt = S_DONE;
          else                             state_nxt = S_GEN;
        end else if (timeout_hit) begin
          state_nxt = S_DONE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (state == S_GEN) q_mem[q_wr_ptr] <= '{addr: gen_addr, bl: gen_bl, key: lfsr};
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      mode_r         <= '0;
      base_r         <= '0;
      mask_r         <= '0;
      blm_r          <= '0;
      grp_r          <= '0;
      iter_r         <= '0;
      offset         <= '0;
      lfsr           <= SEED;
      q_wr_ptr       <= '0;
      q_rd_ptr       <= '0;
      q_count        <= '0;
      cur_addr       <= '0;
      beats_left     <= '0;
      cur_key        <= '0;
      wait_cnt       <= '0;
    end else begin
      if (accept_start) begin
        mode_r         <= mode;
        base_r         <= cfg_base_addr;
        mask_r         <= cfg_addr_mask;
        blm_r          <= cfg_bl_mask;
        grp_r          <= grp_clamped;
        iter_r         <= cfg_num_iter;
        offset         <= '0;
        timeout_err    <= 1'b0;
        err_cnt        <= '0;
        first_err_addr <= '0;
        done           <= (cfg_num_iter == 16'd0);
      end else if (state_nxt == S_DONE && state != S_DONE) begin
        done <= 1'b1;
      end

      if (in_burst && !wb.wb_ack_i) wait_cnt <= wait_cnt + TW'(1);
      else                          wait_cnt <= '0;

      if (state == S_GEN) begin
        cur_addr   <= gen_addr;
        beats_left <= gen_bl;
        cur_key    <= lfsr;
        lfsr       <= lfsr_next;
        q_wr_ptr   <= q_wr_ptr + QAW'(1);
        q_count    <= q_count + (QAW+1)'(1);
        if (mode_r == 2'b01) offset <= offset + (AW'(gen_bl) << LSB);
      end

      if (state == S_POP) begin
        cur_addr   <= q_mem[q_rd_ptr].addr;
        beats_left <= q_mem[q_rd_ptr].bl;
        cur_key    <= q_mem[q_rd_ptr].key;
        q_rd_ptr   <= q_rd_ptr + QAW'(1);
        q_count    <= q_count - (QAW+1)'(1);
      end

      if (beat_ack) begin
        cur_addr   <= cur_addr + AW'(NB);
        beats_left <= beats_left - (BLW+1)'(1);
        if (state == S_RD && wb.wb_dat_i != pattern) begin
          if (err_cnt == 32'd0)           first_err_addr <= cur_addr;
          if (err_cnt != 32'hFFFF_FFFF)   err_cnt <= err_cnt + 32'd1;
        end
        if (state == S_RD && last_beat && q_count == '0) iter_r <= iter_r - 16'd1;
      end

      // An abandoned burst leaves stale descriptors behind; drop them so the next run starts clean.
      if (timeout_hit) begin
        timeout_err <= 1'b1;
        q_wr_ptr    <= '0;
        q_rd_ptr    <= '0;
        q_count     <= '0;
      end
    end
  end
endmodule

// File: tb/tb_wb_sdr_traffic_gen.sv
// tb/tb_wb_sdr_traffic_gen.sv - directed bench with a stalling Wishbone memory slave and a burst model
module tb_wb_sdr_traffic_gen;
  localparam int          AW   = 26;
  localparam logic [31:0] SEED = 32'hACE1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [1:0]    mode = '0;
  logic [AW-1:0] base = '0, mask = '0;
  logic [3:0]    blm = '0, grp = '0;
  logic [15:0]   iter = '0;
  logic          busy, done, timeout_err;
  logic [31:0]   err_cnt;
  logic [AW-1:0] first_err_addr;

  int            n_checks = 0, n_errors = 0;
  logic [31:0]   mem [logic [AW-1:0]];
  logic [63:0]   log_q [$];
  logic [63:0]   exp_q [$];
  int            rd_bursts = 0, corrupt_burst = 0;
  bit            noack = 1'b0;
  logic [31:0]   m_lfsr = SEED;

  wb_sdr_traffic_gen_if #(.DW(32), .AW(AW)) wbi ();

  wb_sdr_traffic_gen #(.DW(32), .AW(AW), .BLW(4), .QDEPTH(8), .TIMEOUT(16), .SEED(SEED)) dut (
    .wb_clk_i       (clk),
    .wb_rst_i       (rst),
    .start          (start),
    .mode           (mode),
    .cfg_base_addr  (base),
    .cfg_addr_mask  (mask),
    .cfg_bl_mask    (blm),
    .cfg_group      (grp),
    .cfg_num_iter   (iter),
    .busy           (busy),
    .done           (done),
    .timeout_err    (timeout_err),
    .err_cnt        (err_cnt),
    .first_err_addr (first_err_addr),
    .wb             (wbi)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return l[0] ? ((l >> 1) ^ 32'h8020_0003) : (l >> 1);
  endfunction

  function automatic logic [63:0] pack(input logic we, input logic [2:0] cti,
                                       input logic [AW-1:0] a, input logic [31:0] d);
    return {2'b00, we, cti, a, d};
  endfunction

  function automatic logic [63:0] log_at(input int i);
    return (log_q.size() > i) ? log_q[i] : 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  // Memory slave: ack is raised at a falling edge after 0-3 idle cycles and taken by the next rising edge.
  initial begin
    logic [AW-1:0] a;
    logic [31:0]   d;
    int            stall;
    bit            first;
    wbi.wb_ack_i = 1'b0;
    wbi.wb_dat_i = '0;
    stall = 0;
    first = 1'b1;
    forever begin
      @(negedge clk);
      if (!wbi.wb_cyc_o) first = 1'b1;
      if (rst) begin
        wbi.wb_ack_i = 1'b0;
      end else if (wbi.wb_ack_i) begin
        wbi.wb_ack_i = 1'b0;
        stall = $urandom_range(0, 3);
      end else if (wbi.wb_cyc_o && wbi.wb_stb_o && !noack) begin
        if (stall > 0) begin
          stall--;
        end else begin
          a = wbi.wb_addr_o;
          if (wbi.wb_we_o) begin
            mem[a] = wbi.wb_dat_o;
            log_q.push_back(pack(1'b1, wbi.wb_cti_o, a, wbi.wb_dat_o));
          end else begin
            if (first) rd_bursts++;
            d = mem.exists(a) ? mem[a] : 32'h0;
            if (first && rd_bursts == corrupt_burst) d = d ^ 32'h1;
            wbi.wb_dat_i = d;
            log_q.push_back(pack(1'b0, wbi.wb_cti_o, a, 32'h0));
          end
          first = 1'b0;
          wbi.wb_ack_i = 1'b1;
        end
      end
    end
  end

  task automatic run(input logic [1:0] md, input logic [AW-1:0] b, input logic [AW-1:0] mk,
                     input logic [3:0] bm, input logic [3:0] gp, input logic [15:0] it,
                     input int corrupt, input bit poke, input string name);
    logic [AW-1:0] d_addr [$];
    int            d_bl   [$];
    logic [31:0]   d_key  [$];
    logic [31:0]   mm [logic [AW-1:0]];
    logic [AW-1:0] off, a, ad, e_first;
    logic [31:0]   L, d;
    int            bl, g, rdb, e_err, wait_n;
    g = (gp == 0) ? 1 : ((gp > 8) ? 8 : int'(gp));
    off = '0; rdb = 0; e_err = 0; e_first = '0;
    exp_q.delete();
    for (int i = 0; i < int'(it); i++) begin
      d_addr.delete(); d_bl.delete(); d_key.delete();
      for (int j = 0; j < g; j++) begin
        L = m_lfsr;
        m_lfsr = lfsr_step(L);
        if (md[1]) begin
          a  = (b + (L[AW-1:0] & mk)) & ~26'h3;
          bl = int'(L[3:0] & bm) + 1;
        end else begin
          a  = md[0] ? (b + (off & mk)) : b;
          bl = int'(bm) + 1;
        end
        if (md == 2'b01) off = off + AW'(bl * 4);
        d_addr.push_back(a); d_bl.push_back(bl); d_key.push_back(L);
        for (int k = 0; k < bl; k++) begin
          ad = a + AW'(k * 4);
          mm[ad] = L ^ 32'(ad);
          exp_q.push_back(pack(1'b1, (k == bl - 1) ? 3'b111 : 3'b010, ad, L ^ 32'(ad)));
        end
      end
      for (int j = 0; j < g; j++) begin
        rdb++;
        for (int k = 0; k < d_bl[j]; k++) begin
          ad = d_addr[j] + AW'(k * 4);
          d  = mm[ad];
          if (k == 0 && rdb == corrupt) d = d ^ 32'h1;
          if (d != (d_key[j] ^ 32'(ad))) begin
            if (e_err == 0) e_first = ad;
            e_err++;
          end
          exp_q.push_back(pack(1'b0, (k == d_bl[j] - 1) ? 3'b111 : 3'b010, ad, 32'h0));
        end
      end
    end

    mode = md; base = b; mask = mk; blm = bm; grp = gp; iter = it;
    corrupt_burst = corrupt; rd_bursts = 0; log_q.delete();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, ":done_clr"}, done, 1'b0);
    check({name, ":busy"}, busy, 1'b1);
    check({name, ":cyc_gen"}, wbi.wb_cyc_o, 1'b0);
    @(negedge clk);
    check({name, ":cyc_lat2"}, wbi.wb_cyc_o, 1'b1);
    if (poke) begin
      mode = 2'b01; base = 26'h12340; blm = 4'hF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_n = 0;
    while (!done && wait_n < 20000) begin
      @(negedge clk);
      wait_n++;
    end
    check({name, ":done"}, done, 1'b1);
    check({name, ":busy_end"}, busy, 1'b0);
    check({name, ":timeout_err"}, timeout_err, 1'b0);
    check({name, ":err_cnt"}, err_cnt, e_err);
    check({name, ":first_err_addr"}, first_err_addr, e_first);
    check({name, ":beats"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s:beat%0d", name, i), log_at(i), exp_q[i]);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst:cyc", wbi.wb_cyc_o, 1'b0);
    check("rst:stb", wbi.wb_stb_o, 1'b0);
    check("rst:we", wbi.wb_we_o, 1'b0);
    check("rst:sel", wbi.wb_sel_o, 4'h0);
    check("rst:cti", wbi.wb_cti_o, 3'b000);
    check("rst:addr", wbi.wb_addr_o, '0);
    check("rst:dat", wbi.wb_dat_o, '0);
    check("rst:busy", busy, 1'b0);
    check("rst:done", done, 1'b0);
    check("rst:timeout_err", timeout_err, 1'b0);
    check("rst:err_cnt", err_cnt, 32'h0);
    check("rst:first_err_addr", first_err_addr, '0);
    rst = 1'b0;
    @(negedge clk);

    run(2'b00, 26'h40000, 26'h0, 4'h3, 4'h1, 16'd1, 0, 1'b1, "t1");
    check("t1:w0", log_at(0), pack(1'b1, 3'b010, 26'h40000, 32'h0004ACE1));
    check("t1:w3", log_at(3), pack(1'b1, 3'b111, 26'h4000C, 32'h0004ACED));
    check("t1:r0", log_at(4), pack(1'b0, 3'b010, 26'h40000, 32'h0));

    run(2'b01, 26'hFF0, 26'hFFF, 4'hF, 4'h8, 16'd3, 0, 1'b0, "t2");
    check("t2:page_cross", log_at(4) >> 32, 64'h1000 | (64'h1 << 29) | (64'h2 << 26));

    mode = 2'b00; base = 26'h40000; blm = 4'h3; grp = 4'h1; iter = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!(wbi.wb_cyc_o && wbi.wb_we_o && wbi.wb_addr_o == 26'h40004) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t5:beat2_seen", n < 100, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_lfsr = SEED;
    check("t5:cyc", wbi.wb_cyc_o, 1'b0);
    check("t5:stb", wbi.wb_stb_o, 1'b0);
    check("t5:busy", busy, 1'b0);
    check("t5:err_cnt", err_cnt, 32'h0);
    check("t5:done", done, 1'b0);

    iter = 16'd0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t6:done_iter0", done, 1'b1);
    check("t6:busy_iter0", busy, 1'b0);
    n = 0;
    repeat (5) begin
      if (wbi.wb_cyc_o) n++;
      @(negedge clk);
    end
    check("t6:no_cyc", n, 0);

    run(2'b00, 26'h40000, 26'h0, 4'h3, 4'h1, 16'd1, 0, 1'b0, "t5b");
    check("t5b:w0", log_at(0), pack(1'b1, 3'b010, 26'h40000, 32'h0004ACE1));

    run(2'b10, 26'h100000, 26'hFFFFF, 4'h3, 4'h2, 16'd20, 3, 1'b0, "t3");

    noack = 1'b1;
    mode = 2'b00; base = 26'h2000; blm = 4'h3; grp = 4'h1; iter = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!wbi.wb_cyc_o && n < 10) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (wbi.wb_cyc_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("t4:cyc_cycles", n, 17);
    check("t4:timeout_err", timeout_err, 1'b1);
    check("t4:done", done, 1'b1);
    check("t4:busy", busy, 1'b0);
    noack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
